// File: rtl/ifetch_queue.sv
// ============================================================================
// Module   : ifetch_queue
// Purpose  : Fetch PC owner plus a small {pc, instr} FIFO feeding decode over
//            valid/ready. Redirects flush the queue and restart fetch.
//            Optional perf counters are enabled by defining IFETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [10:0]                imem_a,
    input  logic [31:0]                imem_rd,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic [$clog2(DEPTH):0]     q_count
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]                perf_fetch,
    output logic [31:0]                perf_flush
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [31:0]        pc_q,     pc_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;

    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_instr [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_unused;

    // Low PC bits of a redirect target are forced to zero, never consumed.
    assign w_unused = ^redirect_pc[1:0];

    assign instr_valid = (count_q != '0);
    assign w_pop       = instr_valid & instr_ready & ~redirect_valid;
    assign w_push      = fetch_en & ~redirect_valid & ((count_q < c_depth) | w_pop);

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                pc_d     = pc_q + 32'd4;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is always read from here so an empty
    // queue never forwards imem_rd to the outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_pc[wr_ptr_q]    <= pc_q;
            mem_instr[wr_ptr_q] <= imem_rd;
        end
    end

    assign imem_a   = pc_q[12:2];
    assign instr    = mem_instr[rd_ptr_q];
    assign instr_pc = mem_pc[rd_ptr_q];
    assign q_count  = count_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, w_push};
        perf_flush_d = perf_flush_q + {31'd0, redirect_valid};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// ============================================================================
// Module   : tb_ifetch_queue
// Purpose  : Self-checking bench for ifetch_queue against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [10:0] imem_a;
    logic [31:0] imem_rd;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  q_count;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    always #5 clk = ~clk;

    // Memory word i holds 32'h1000_0000 + i.
    assign imem_rd = 32'h1000_0000 + {21'd0, imem_a};

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .q_count        (q_count)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch     (perf_fetch),
        .perf_flush     (perf_flush)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_pf;
    logic [31:0] m_pfl;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000_0000 + {21'd0, pc[12:2]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = RESET_PC;
        m_pf  = 32'd0;
        m_pfl = 32'd0;
    endtask

    task automatic compare();
        logic [31:0] sz;
        sz = mq.size();
        chk("valid",   {31'd0, instr_valid}, {31'd0, (sz != 0)});
        chk("q_count", {29'd0, q_count}, sz);
        chk("imem_a",  {21'd0, imem_a}, {21'd0, m_pc[12:2]});
        if (sz != 0) begin
            chk("instr",    instr,    mq[0].ins);
            chk("instr_pc", instr_pc, mq[0].pc);
        end
`ifdef IFETCH_PERF_EN
        chk("perf_fetch", perf_fetch, m_pf);
        chk("perf_flush", perf_flush, m_pfl);
`endif
    endtask

    // Called at a falling edge: check, drive, advance model across next rising edge.
    task automatic cycle(input logic fen, input logic rdy, input logic rv, input logic [31:0] rpc);
        bit   v, pop, push;
        ent_t e;
        compare();
        fetch_en       = fen;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        v    = (mq.size() != 0);
        pop  = v & rdy & ~rv;
        push = fen & ~rv & ((mq.size() < DEPTH) || pop);
        if (rv) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            m_pfl++;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc  = m_pc;
                e.ins = word_at(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
                m_pf++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        reset_b        = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_b = 1'b1;

        chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("rst_qcount", {29'd0, q_count}, 32'd0);
        chk("rst_imem_a", {21'd0, imem_a}, 32'd0);

        // Stall: occupancy climbs to full and fetch stops at pc 16.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'd0);
            chk("stall_qcount", {29'd0, q_count}, (i < 3) ? 32'(i + 1) : 32'd4);
        end
        chk("stall_imem_a", {21'd0, imem_a}, 32'd4);

        // Drain while full: one per cycle, in order, occupancy stays at 4.
        for (int k = 0; k < 5; k++) begin
            chk("full_pc",     instr_pc, 32'(4 * k));
            chk("full_qcount", {29'd0, q_count}, 32'd4);
            cycle(1'b1, 1'b1, 1'b0, 32'd0);
        end

        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        chk("pre_redir_qcount", {29'd0, q_count}, 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("redir_qcount", {29'd0, q_count}, 32'd0);
        chk("redir_valid",  {31'd0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir_valid2", {31'd0, instr_valid}, 32'd1);
        chk("redir_pc",     instr_pc, 32'h0000_0100);
        chk("redir_instr",  instr, 32'h1000_0040);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else
                rpc = $urandom;
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 3),
                  ($urandom_range(0, 19) == 0), rpc);
        end

        // Async reset mid-cycle with a full queue.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        #2 reset_b = 1'b0;
        #1;
        chk("async_valid",  {31'd0, instr_valid}, 32'd0);
        chk("async_qcount", {29'd0, q_count}, 32'd0);
        chk("async_imem_a", {21'd0, imem_a}, {21'd0, RESET_PC[12:2]});
        model_reset();
        @(negedge clk);
        reset_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'd0);
            chk("stream_pc",    instr_pc, 32'(4 * k));
            chk("stream_instr", instr, 32'h1000_0000 + 32'(k));
        end

`ifdef IFETCH_PERF_EN
        #2 reset_b = 1'b0;
        model_reset();
        @(negedge clk);
        reset_b = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("perf_fetch_lit", perf_fetch, 32'd13);
        chk("perf_flush_lit", perf_flush, 32'd1);
`endif

        compare();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
